// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcode encoding and default datapath width.
package alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_ABSD = 4'd2,
    OP_MUL  = 4'd3,
    OP_DIV  = 4'd4,
    OP_MOD  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10
  } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode bundle driven into the ALU and its registered result and flags.
interface alu_if #(parameter int N = 4) ();

  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   select;
  logic [N-1:0] outMux;
  logic         Cout;
  logic         NegFlag;
  logic         zeroFlag;

  modport master (output a, b, select, input outMux, Cout, NegFlag, zeroFlag);
  modport slave  (input a, b, select, output outMux, Cout, NegFlag, zeroFlag);

endinterface

// File: rtl/alu_divider.sv
// Combinational unsigned restoring divider; quotient/remainder are undefined when
// div_by_zero is set and the caller substitutes its own values.
module alu_divider #(
  parameter int N = 4
) (
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  logic [N:0] rem;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned (no latch); blocking '=' is required here because each
    // iteration reads the partial remainder the previous one just wrote.
    rem      = '0;
    quotient = '0;
    for (int i = N - 1; i >= 0; i--) begin
      rem = {rem[N-1:0], dividend[i]};
      if (rem >= {1'b0, divisor}) begin
        rem         = rem - {1'b0, divisor};
        quotient[i] = 1'b1;
      end
    end
    remainder = rem[N-1:0];
  end

  assign div_by_zero = (divisor == '0);

endmodule

// File: rtl/alu_unit.sv
// 4-bit registered ALU: opcode mux plus carry/negative/zero flags, one register stage.
// Define ALU_DIV_EN to build DIV/MOD; otherwise those opcodes behave as reserved.
module alu_unit
  import alu_pkg::*;
#(
  parameter int N = ALU_W
) (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  logic [N-1:0]   res;
  logic           carry;
  logic           neg;
  logic [N:0]     sum;
  logic [2*N-1:0] prod;
  logic           a_lt_b;

  assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
  assign prod   = {{N{1'b0}}, bus.a} * {{N{1'b0}}, bus.b};
  assign a_lt_b = (bus.a < bus.b);

`ifdef ALU_DIV_EN
  logic [N-1:0] quot;
  logic [N-1:0] rmd;
  logic         dbz;

  alu_divider #(.N(N)) u_div (
    .dividend    (bus.a),
    .divisor     (bus.b),
    .quotient    (quot),
    .remainder   (rmd),
    .div_by_zero (dbz)
  );
`endif

  always_comb begin
    res   = '0;
    carry = 1'b0;
    neg   = 1'b0;
    case (alu_op_e'(bus.select))
      OP_ADD: begin
        res   = sum[N-1:0];
        carry = sum[N];
      end
      OP_SUB: begin
        res   = bus.a - bus.b;
        carry = a_lt_b;
        neg   = a_lt_b;
      end
      OP_ABSD: begin
        res = a_lt_b ? (bus.b - bus.a) : (bus.a - bus.b);
        neg = a_lt_b;
      end
      OP_MUL: begin
        res   = prod[N-1:0];
        carry = |prod[2*N-1:N];
      end
`ifdef ALU_DIV_EN
      OP_DIV: begin
        res   = dbz ? '1 : quot;
        carry = dbz;
      end
      OP_MOD: begin
        res   = dbz ? bus.a : rmd;
        carry = dbz;
      end
`endif
      OP_AND: res = bus.a & bus.b;
      OP_OR:  res = bus.a | bus.b;
      OP_XOR: res = bus.a ^ bus.b;
      OP_SHL: begin
        res   = {bus.a[N-2:0], 1'b0};
        carry = bus.a[N-1];
      end
      OP_SHR: begin
        res   = {1'b0, bus.a[N-1:1]};
        carry = bus.a[0];
      end
      default: ;
    endcase
  end

  // NOTE: only the output register needs reset; zeroFlag resets to 1 so it
  // stays consistent with the cleared result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.outMux   <= '0;
      bus.Cout     <= 1'b0;
      bus.NegFlag  <= 1'b0;
      bus.zeroFlag <= 1'b1;
    end else begin
      bus.outMux   <= res;
      bus.Cout     <= carry;
      bus.NegFlag  <= neg;
      bus.zeroFlag <= (res == '0);
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed opcode cases, async reset, random vs. model.
module tb_alu_unit;
  import alu_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  alu_if #(.N(W)) bus ();

  alu_unit #(.N(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] o;
    logic       c;
    logic       n;
    logic       z;
  } exp_t;

  // Arithmetic reference built from integer math rather than bit slicing.
  function automatic exp_t model(input int ua, input int ub, input int sel);
    exp_t e;
    int   r;
    int   c;
    int   n;
    r = 0; c = 0; n = 0;
    case (sel)
      0: begin r = (ua + ub) % 16; c = ((ua + ub) >= 16) ? 1 : 0; end
      1: begin r = (ua - ub + 16) % 16; c = (ua < ub) ? 1 : 0; n = c; end
      2: begin r = (ua < ub) ? ub - ua : ua - ub; n = (ua < ub) ? 1 : 0; end
      3: begin r = (ua * ub) % 16; c = ((ua * ub) >= 16) ? 1 : 0; end
`ifdef ALU_DIV_EN
      4: begin r = (ub == 0) ? 15 : ua / ub; c = (ub == 0) ? 1 : 0; end
      5: begin r = (ub == 0) ? ua : ua % ub; c = (ub == 0) ? 1 : 0; end
`endif
      6: r = ua & ub;
      7: r = ua | ub;
      8: r = ua ^ ub;
      9: begin r = (ua * 2) % 16; c = (ua >= 8) ? 1 : 0; end
      10: begin r = ua / 2; c = ua % 2; end
      default: ;
    endcase
    e.o = 4'(r);
    e.c = (c != 0);
    e.n = (n != 0);
    e.z = (r == 0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".out"},  bus.outMux,          e.o);
    check({tag, ".cout"}, {3'b0, bus.Cout},     {3'b0, e.c});
    check({tag, ".neg"},  {3'b0, bus.NegFlag},  {3'b0, e.n});
    check({tag, ".zero"}, {3'b0, bus.zeroFlag}, {3'b0, e.z});
  endtask

  task automatic apply(input int ua, input int ub, input int sel);
    @(negedge clk);
    bus.a      = 4'(ua);
    bus.b      = 4'(ub);
    bus.select = 4'(sel);
    @(posedge clk);
    #1;
  endtask

  // Directed step with expected values written out by hand.
  task automatic step(input string tag, input int ua, input int ub, input int sel,
                      input int eo, input bit ec, input bit en);
    exp_t e;
    apply(ua, ub, sel);
    e.o = 4'(eo);
    e.c = ec;
    e.n = en;
    e.z = (eo == 0);
    check_all(tag, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   ra;
    int   rb;
    int   rs;

    bus.a = '0; bus.b = '0; bus.select = '0;
    #12;
    e = '{o: 4'd0, c: 1'b0, n: 1'b0, z: 1'b1};
    check_all("reset", e);
    @(negedge clk);
    rst = 1'b0;

    step("add9_5",  9, 5, 0, 14, 0, 0);
    step("absd9_5", 9, 5, 2, 4,  0, 0);
    step("mul9_5",  9, 5, 3, 13, 1, 0);
    step("and9_5",  9, 5, 6, 1,  0, 0);
    step("or9_5",   9, 5, 7, 13, 0, 0);
    step("xor9_5",  9, 5, 8, 12, 0, 0);
    step("shl9",    9, 5, 9, 2,  1, 0);
    step("shr9",    9, 5, 10, 4, 1, 0);
    step("absd2_4", 2, 4, 2, 2,  0, 1);
    step("mul2_4",  2, 4, 3, 8,  0, 0);
    step("shl2",    2, 4, 9, 4,  0, 0);
    step("shr2",    2, 4, 10, 1, 0, 0);
    step("add12_12", 12, 12, 0, 8, 1, 0);
    step("sub12_12", 12, 12, 1, 0, 0, 0);
    step("add0_0",  0, 0, 0, 0,  0, 0);
    step("sub10_7", 10, 7, 1, 3,  0, 0);
    step("sub4_9",  4, 9, 1, 11,  1, 1);
    step("sub15_2", 15, 2, 1, 13, 0, 0);
    step("sub2_15", 2, 15, 1, 3,  1, 1);
    step("sub8_8",  8, 8, 1, 0,   0, 0);
    step("rsvd12",  7, 0, 12, 0,  0, 0);
    step("rsvd15",  15, 15, 15, 0, 0, 0);
`ifdef ALU_DIV_EN
    step("div9_5",  9, 5, 4, 1,  0, 0);
    step("mod9_5",  9, 5, 5, 4,  0, 0);
    step("div2_4",  2, 4, 4, 0,  0, 0);
    step("mod2_4",  2, 4, 5, 2,  0, 0);
    step("div7_0",  7, 0, 4, 15, 1, 0);
    step("mod7_0",  7, 0, 5, 7,  1, 0);
`else
    step("div_off", 9, 5, 4, 0,  0, 0);
    step("mod_off", 7, 0, 5, 0,  0, 0);
`endif

    // Asynchronous reset must clear the outputs before any clock edge.
    step("pre_rst", 9, 5, 0, 14, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    e = '{o: 4'd0, c: 1'b0, n: 1'b0, z: 1'b1};
    check_all("async_rst", e);
    @(posedge clk);
    #1;
    check_all("rst_hold", e);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 4, 9, 1, 11, 1, 1);

    for (int i = 0; i < 300; i++) begin
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      rs = int'($urandom_range(0, 15));
      apply(ra, rb, rs);
      e = model(ra, rb, rs);
      check_all($sformatf("rnd%0d_op%0d_a%0d_b%0d", i, rs, ra, rb), e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
